// File: rtl/freq_div_multi.sv
// freq_div_multi: NUM_CH independent programmable clock dividers.
//
// Each channel divides clk_i by an active divisor D. With D >= 2 the output
// is a registered clock that is low for ceil(D/2) and high for floor(D/2)
// clk_i cycles. D = 0 or 1 selects bypass, where clk_o is clk_i gated by en_i.
// A new divisor requested while a channel is running is held as pending and
// only takes effect at a period boundary, which is the edge where the output
// falls. Because of this, no phase is ever stretched or truncated.
//
// Optional feature: define FREQ_DIV_MULTI_TICK_EN to add tick_o. tick_o is a
// one-cycle pulse in the first clk_i cycle that each divided clock is high.
//
// Ports:
//   clk_i      source clock (rising edge)
//   arst_ni    asynchronous active-low reset
//   en_i       per-channel run enable
//   divisor_i  per-channel requested divisor (NUM_CH x DIVISOR_SIZE)
//   load_i     per-channel request to adopt divisor_i
//   pend_o     per-channel: captured divisor awaiting the next boundary
//   clk_o      per-channel divided clock
//   tick_o     (FREQ_DIV_MULTI_TICK_EN only) per-channel rise-aligned pulse
module freq_div_multi #(
  parameter int NUM_CH       = 4,
  parameter int DIVISOR_SIZE = 9,
  parameter int DEFAULT_DIV  = 2
) (
  input  logic                                clk_i,
  input  logic                                arst_ni,
  input  logic [NUM_CH-1:0]                   en_i,
  input  logic [NUM_CH-1:0][DIVISOR_SIZE-1:0] divisor_i,
  input  logic [NUM_CH-1:0]                   load_i,
  output logic [NUM_CH-1:0]                   pend_o,
  output logic [NUM_CH-1:0]                   clk_o
`ifdef FREQ_DIV_MULTI_TICK_EN
  ,
  output logic [NUM_CH-1:0]                   tick_o
`endif
);

  localparam logic [DIVISOR_SIZE-1:0] MIN_DIV = DIVISOR_SIZE'(2);
  localparam logic [DIVISOR_SIZE-1:0] RST_DIV = DIVISOR_SIZE'(DEFAULT_DIV);

  // ST_IDLE covers both a parked channel and bypass (D < 2). In either case
  // clk_q is held low.
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t                  state, state_n;
    logic [DIVISOR_SIZE-1:0] d, d_n;
    logic [DIVISOR_SIZE-1:0] p, p_n;
    logic [DIVISOR_SIZE-1:0] cnt, cnt_n;
    logic [DIVISOR_SIZE-1:0] low_len;
    logic                    pend, pend_n;
    logic                    clk_q, clk_q_n;

    // ceil(D/2) is computed without an adder carry-out, so D = 2^N-1 cannot wrap.
    assign low_len = (d >> 1) + DIVISOR_SIZE'(d[0]);

    always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
        state <= ST_IDLE;
        d     <= RST_DIV;
        p     <= '0;
        pend  <= 1'b0;
        cnt   <= '0;
        clk_q <= 1'b0;
      end else begin
        state <= state_n;
        d     <= d_n;
        p     <= p_n;
        pend  <= pend_n;
        cnt   <= cnt_n;
        clk_q <= clk_q_n;
      end
    end

    always_comb begin
      state_n = state;
      d_n     = d;
      p_n     = p;
      pend_n  = pend;
      cnt_n   = cnt;
      clk_q_n = clk_q;
      case (state)
        ST_IDLE: begin
          // A load is applied directly while idle. Enabling starts a full low
          // phase from this edge, and the new divisor is already in effect.
          if (load_i[c]) d_n = divisor_i[c];
          pend_n  = 1'b0;
          cnt_n   = '0;
          clk_q_n = 1'b0;
          if (en_i[c] && (d_n >= MIN_DIV)) state_n = ST_RUN;
        end
        ST_RUN: begin
          if (cnt == d - 1'b1) begin
            // Period boundary: clk_q falls here. A coincident load takes
            // priority over a pending divisor.
            if (load_i[c])  d_n = divisor_i[c];
            else if (pend)  d_n = p;
            pend_n  = 1'b0;
            cnt_n   = '0;
            clk_q_n = 1'b0;
            if (!en_i[c] || (d_n < MIN_DIV)) state_n = ST_IDLE;
          end else if (!en_i[c] && !clk_q) begin
            // Disabled during the low phase: park at once. Any captured
            // divisor is applied now, because the parked state has no
            // pending slot.
            if (load_i[c])  d_n = divisor_i[c];
            else if (pend)  d_n = p;
            pend_n  = 1'b0;
            cnt_n   = '0;
            clk_q_n = 1'b0;
            state_n = ST_IDLE;
          end else begin
            // Mid-period, or finishing a high phase after disable.
            if (load_i[c]) begin
              p_n    = divisor_i[c];
              pend_n = 1'b1;
            end
            cnt_n   = cnt + 1'b1;
            clk_q_n = (cnt_n >= low_len);
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    assign pend_o[c] = pend;
    assign clk_o[c]  = (d < MIN_DIV) ? (clk_i & en_i[c]) : clk_q;

`ifdef FREQ_DIV_MULTI_TICK_EN
    logic tick;

    always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) tick <= 1'b0;
      else          tick <= clk_q_n & ~clk_q;
    end

    assign tick_o[c] = tick;
`endif
  end

endmodule

// File: tb/tb_freq_div_multi.sv
// Directed self-checking bench for freq_div_multi (NUM_CH=4, DIVISOR_SIZE=9).
// Outputs are sampled 1 time unit after the rising edge of clk_i.
module tb_freq_div_multi;

  logic             clk_i = 1'b0;
  logic             arst_ni;
  logic [3:0]       en;
  logic [3:0]       load;
  logic [3:0][8:0]  div;
  logic [3:0]       pend;
  logic [3:0]       clko;
`ifdef FREQ_DIV_MULTI_TICK_EN
  logic [3:0]       tick;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  freq_div_multi #(
    .NUM_CH      (4),
    .DIVISOR_SIZE(9),
    .DEFAULT_DIV (2)
  ) dut (
    .clk_i    (clk_i),
    .arst_ni  (arst_ni),
    .en_i     (en),
    .divisor_i(div),
    .load_i   (load),
    .pend_o   (pend),
    .clk_o    (clko)
`ifdef FREQ_DIV_MULTI_TICK_EN
    ,
    .tick_o   (tick)
`endif
  );

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic park_all();
    en   = 4'h0;
    load = 4'h0;
    repeat (300) cyc();
  endtask

  task automatic test_reset();
    arst_ni = 1'b0;
    en      = 4'hF;
    load    = 4'h0;
    div     = '0;
    #1;
    checks++;
    if (clko !== 4'h0) begin failures++; $display("FAIL reset_clk got=%b want=0000", clko); end
    checks++;
    if (pend !== 4'h0) begin failures++; $display("FAIL reset_pend got=%b want=0000", pend); end
`ifdef FREQ_DIV_MULTI_TICK_EN
    checks++;
    if (tick !== 4'h0) begin failures++; $display("FAIL reset_tick got=%b want=0000", tick); end
`endif
    repeat (2) cyc();
    checks++;
    if (clko !== 4'h0) begin failures++; $display("FAIL reset_hold_clk got=%b want=0000", clko); end
    en = 4'h0;
    #3 arst_ni = 1'b1;
    cyc();
    checks++;
    if (clko !== 4'h0) begin failures++; $display("FAIL reset_idle_clk got=%b want=0000", clko); end
  endtask

  task automatic test_default_div();
    logic [3:0] ev;
    en = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      ev    = 4'h0;
      ev[0] = (k % 2) == 0;
      checks++;
      if (clko !== ev) begin failures++; $display("FAIL default_div k=%0d got=%b want=%b", k, clko, ev); end
    end
  endtask

  task automatic test_div5();
    logic [3:0] ev;
    park_all();
    load[0] = 1'b1;
    div[0]  = 9'd5;
    cyc();
    load = 4'h0;
    checks++;
    if (pend !== 4'h0) begin failures++; $display("FAIL div5_idle_pend got=%b want=0000", pend); end
    en[0] = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      cyc();
      ev    = 4'h0;
      ev[0] = ((k - 1) % 5) >= 3;
      checks++;
      if (clko !== ev) begin failures++; $display("FAIL div5 k=%0d got=%b want=%b", k, clko, ev); end
`ifdef FREQ_DIV_MULTI_TICK_EN
      ev    = 4'h0;
      ev[0] = ((k - 1) % 5) == 3;
      checks++;
      if (tick !== ev) begin failures++; $display("FAIL div5_tick k=%0d got=%b want=%b", k, tick, ev); end
`endif
    end
  endtask

  task automatic test_pending();
    logic [3:0] ev, pv;
    park_all();
    load[0] = 1'b1;
    div[0]  = 9'd4;
    cyc();
    load[0] = 1'b0;
    en[0]   = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      load[0] = (k == 3) || (k == 4) || (k == 12);
      div[0]  = (k == 3) ? 9'd6 : ((k == 4) ? 9'd7 : 9'd3);
      cyc();
      ev = 4'h0;
      if (k <= 4)       ev[0] = (k - 1) >= 2;
      else if (k <= 11) ev[0] = (k - 5) >= 4;
      else              ev[0] = ((k - 12) % 3) >= 2;
      pv    = 4'h0;
      pv[0] = (k == 3) || (k == 4);
      checks++;
      if (clko !== ev) begin failures++; $display("FAIL pending_clk k=%0d got=%b want=%b", k, clko, ev); end
      checks++;
      if (pend !== pv) begin failures++; $display("FAIL pending_flag k=%0d got=%b want=%b", k, pend, pv); end
    end
    load = 4'h0;
  endtask

  task automatic test_disable();
    logic [3:0] ev;
    park_all();
    load[0] = 1'b1;
    div[0]  = 9'd6;
    cyc();
    load[0] = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      en[0] = !((k >= 5 && k <= 10) || k == 18 || k == 19);
      cyc();
      ev = 4'h0;
      if (k <= 4)       ev[0] = (k - 1) >= 3;
      else if (k <= 6)  ev[0] = 1'b1;
      else if (k <= 10) ev[0] = 1'b0;
      else if (k <= 17) ev[0] = ((k - 11) % 6) >= 3;
      else if (k <= 19) ev[0] = 1'b0;
      else              ev[0] = (k - 20) >= 3;
      checks++;
      if (clko !== ev) begin failures++; $display("FAIL disable k=%0d got=%b want=%b", k, clko, ev); end
    end
  endtask

  task automatic test_bypass();
    logic [3:0] ev;
    park_all();
    load[0] = 1'b1;
    div[0]  = 9'd1;
    cyc();
    load[0] = 1'b0;
    en[0]   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (clko !== 4'b0001) begin failures++; $display("FAIL bypass_high i=%0d got=%b want=0001", i, clko); end
      #5;
      checks++;
      if (clko !== 4'b0000) begin failures++; $display("FAIL bypass_low i=%0d got=%b want=0000", i, clko); end
    end
    en[0] = 1'b0;
    cyc();
    checks++;
    if (clko !== 4'b0000) begin failures++; $display("FAIL bypass_gated got=%b want=0000", clko); end
    en[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      load[0] = (k == 1);
      div[0]  = 9'd3;
      cyc();
      ev    = 4'h0;
      ev[0] = ((k - 1) % 3) >= 2;
      checks++;
      if (clko !== ev) begin failures++; $display("FAIL bypass_to_div3 k=%0d got=%b want=%b", k, clko, ev); end
      checks++;
      if (pend !== 4'h0) begin failures++; $display("FAIL bypass_pend k=%0d got=%b want=0000", k, pend); end
    end
    load = 4'h0;
  endtask

  task automatic test_multi_reset();
    logic [3:0] ev;
    park_all();
    load   = 4'hF;
    div[0] = 9'd2;
    div[1] = 9'd3;
    div[2] = 9'd8;
    div[3] = 9'd511;
    cyc();
    load = 4'h0;
    en   = 4'hF;
    for (int k = 1; k <= 521; k++) begin
      cyc();
      ev[0] = ((k - 1) % 2) >= 1;
      ev[1] = ((k - 1) % 3) >= 2;
      ev[2] = ((k - 1) % 8) >= 4;
      ev[3] = ((k - 1) % 511) >= 256;
      checks++;
      if (clko !== ev) begin failures++; $display("FAIL multi k=%0d got=%b want=%b", k, clko, ev); end
    end
    load[2] = 1'b1;
    div[2]  = 9'd5;
    cyc();
    load = 4'h0;
    checks++;
    if (pend !== 4'b0100) begin failures++; $display("FAIL multi_pend got=%b want=0100", pend); end
    checks++;
    if (clko[0] !== 1'b1) begin failures++; $display("FAIL multi_prereset ch0 got=%b want=1", clko[0]); end
    #2 arst_ni = 1'b0;
    #1;
    checks++;
    if (clko !== 4'h0) begin failures++; $display("FAIL multi_async_clk got=%b want=0000", clko); end
    checks++;
    if (pend !== 4'h0) begin failures++; $display("FAIL multi_async_pend got=%b want=0000", pend); end
    #3 arst_ni = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      ev = ((k % 2) == 0) ? 4'hF : 4'h0;
      checks++;
      if (clko !== ev) begin failures++; $display("FAIL multi_restart k=%0d got=%b want=%b", k, clko, ev); end
      checks++;
      if (pend !== 4'h0) begin failures++; $display("FAIL multi_restart_pend k=%0d got=%b want=0000", k, pend); end
    end
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_div5();
    test_pending();
    test_disable();
    test_bypass();
    test_multi_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
